moore_serial_pattern_generator: RTL and testbench

Moore-style serial pattern transmitter. It accepts a parallel bit pattern and its length over a valid/ready handshake, then drives the pattern MSB-first onto a single serial line, one bit per clock, repeated a programmable number of times. It is the source end of the serial bit stream consumed by the Moore sequence detectors, and is used as their stimulus and companion block.

---
 rtl/moore_serial_pattern_generator_pkg.sv | 15 +
 rtl/moore_serial_pattern_generator_if.sv | 32 +++
 rtl/moore_serial_pattern_generator.sv | 106 ++++++++++
 tb/tb_moore_serial_pattern_generator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/moore_serial_pattern_generator_pkg.sv
// Shared definitions for the serial pattern generator: state encoding and
// default sizing.
package moore_serial_pattern_generator_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/moore_serial_pattern_generator_if.sv
// Request handshake and serial output bundle for the pattern generator.
// The repetition count is carried on repeat_n because "repeat" is a keyword.
interface moore_serial_pattern_generator_if
    import moore_serial_pattern_generator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) ();

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] repeat_n;
    logic             abort;
    logic             x;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, pattern, len, repeat_n, abort,
        input  start_ready, x, bit_valid, busy, done
    );

    modport slave (
        input  start_valid, pattern, len, repeat_n, abort,
        output start_ready, x, bit_valid, busy, done
    );

endinterface

// File: rtl/moore_serial_pattern_generator.sv
// Moore serial pattern transmitter: sends a latched pattern MSB-first, one bit
// per clock, for a programmable number of back-to-back repetitions.
//
// state | meaning
// IDLE  | ready for a request; start_ready=1
// SEND  | driving one pattern bit per cycle on x; bit_valid=1
// DONE  | one-cycle done pulse, then back to IDLE
module moore_serial_pattern_generator
    import moore_serial_pattern_generator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic clk,
    input  logic rst,
    moore_serial_pattern_generator_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;

    logic [LEN_W-1:0] len_eff;
    logic [REP_W-1:0] rep_left;
    logic [WIDTH-1:0] aligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
        end
    end

    // Pattern is left-aligned so bit len-1 sits at the MSB and shifts out first.
    always_comb begin
        len_eff  = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
        rep_left = (bus.repeat_n == '0) ? '0 : bus.repeat_n - REP_W'(1);
        aligned  = bus.pattern << (LEN_W'(WIDTH) - len_eff);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    pat_d = aligned;
                    sh_d  = aligned;
                    len_d = len_eff;
                    rep_d = rep_left;
                    if (len_eff == '0) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = len_eff - LEN_W'(1);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.abort || (idx_q == '0 && rep_q == '0)) begin
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    rep_d = rep_q - REP_W'(1);
                    idx_d = len_q - LEN_W'(1);
                    sh_d  = pat_q;
                end else begin
                    idx_d = idx_q - LEN_W'(1);
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.bit_valid   = (state_q == SEND);
    assign bus.x           = (state_q == SEND) & sh_q[WIDTH-1];

endmodule

// File: tb/tb_moore_serial_pattern_generator.sv
// Randomized bench for the serial pattern generator against a bit-queue model.
module tb_moore_serial_pattern_generator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   det_cnt;
    logic [2:0] det_hist;

    moore_serial_pattern_generator_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) bus ();

    moore_serial_pattern_generator #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Precondition: called at a negedge with the DUT in IDLE.
    task automatic run_req(input logic [7:0] pat, input int ln, input int rp,
                           input int abort_at, input bit hold_valid);
        logic exp_q[$];
        int   eff_len;
        int   eff_rep;
        eff_len = (ln > 8) ? 8 : ln;
        eff_rep = (rp == 0) ? 1 : rp;
        for (int r = 0; r < eff_rep; r++)
            for (int i = eff_len - 1; i >= 0; i--)
                exp_q.push_back(pat[i[2:0]]);
        if (abort_at >= 0)
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());

        bus.start_valid = 1'b1;
        bus.pattern     = pat;
        bus.len         = 4'(ln);
        bus.repeat_n    = 4'(rp);
        @(posedge clk);
        #1;
        if (!hold_valid) begin
            bus.start_valid = 1'b0;
            bus.pattern     = 8'($urandom);
            bus.len         = 4'($urandom);
            bus.repeat_n    = 4'($urandom);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check("bit_valid", bus.bit_valid, 1'b1);
            check("x",         bus.x,         exp_q[k]);
            check("busy_send", bus.busy,      1'b1);
            check("ready_send",bus.start_ready, 1'b0);
            check("done_send", bus.done,      1'b0);
            det_hist = {det_hist[1:0], bus.x};
            if (det_hist == 3'b101) det_cnt++;
            bus.abort       = (k == abort_at);
            bus.start_valid = hold_valid ? 1'b1 : 1'($urandom);
        end
        @(negedge clk);
        check("done_pulse",   bus.done,        1'b1);
        check("done_bv",      bus.bit_valid,   1'b0);
        check("done_x",       bus.x,           1'b0);
        check("done_busy",    bus.busy,        1'b1);
        check("done_ready",   bus.start_ready, 1'b0);
        bus.start_valid = hold_valid;
        bus.abort       = 1'($urandom);
        @(negedge clk);
        check("idle_ready",   bus.start_ready, 1'b1);
        check("idle_busy",    bus.busy,        1'b0);
        check("idle_done",    bus.done,        1'b0);
        check("idle_bv",      bus.bit_valid,   1'b0);
        bus.abort = 1'b0;
    endtask

    initial begin
        int  done_seen;
        bit  found;
        n_checks = 0;
        n_errors = 0;
        det_cnt  = 0;
        det_hist = 3'b000;
        rst = 1'b1;
        bus.start_valid = 1'b0;
        bus.pattern     = '0;
        bus.len         = '0;
        bus.repeat_n    = '0;
        bus.abort       = 1'b0;
        #1;
        check("rst_ready", bus.start_ready, 1'b1);
        check("rst_busy",  bus.busy,        1'b0);
        check("rst_done",  bus.done,        1'b0);
        check("rst_bv",    bus.bit_valid,   1'b0);
        check("rst_x",     bus.x,           1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset mid-SEND while bit 3 of 8'hA5 is on the line
        bus.start_valid = 1'b1;
        bus.pattern     = 8'hA5;
        bus.len         = 4'd8;
        bus.repeat_n    = 4'd1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("mid_x_before", bus.x, 1'b0);
        check("mid_bv_before", bus.bit_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_x",     bus.x,           1'b0);
        check("arst_bv",    bus.bit_valid,   1'b0);
        check("arst_busy",  bus.busy,        1'b0);
        check("arst_done",  bus.done,        1'b0);
        check("arst_ready", bus.start_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("arst_no_done", done_seen, 0);

        // 101, single repetition
        run_req(8'b0000_0101, 3, 1, -1, 1'b0);

        // 101 twice, back to back: detector must see two hits
        det_cnt  = 0;
        det_hist = 3'b000;
        run_req(8'b0000_0101, 3, 2, -1, 1'b0);
        check("det_count", det_cnt, 2);

        // len=0: straight to DONE
        run_req(8'hFF, 0, 5, -1, 1'b0);

        // len above WIDTH clamps to WIDTH
        run_req(8'hC3, 12, 1, -1, 1'b0);

        // repeat=0 treated as 1
        run_req(8'h96, 8, 0, -1, 1'b0);

        // abort on 2nd bit of first repetition with start_valid held high
        run_req(8'hFF, 8, 3, 1, 1'b1);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(negedge clk);
        check("reaccept_bv", bus.bit_valid, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        check("drain_done", found, 1'b1);
        @(negedge clk);
        check("drain_idle", bus.start_ready, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int ln;
            int rp;
            int ab;
            ln = $urandom_range(0, 12);
            rp = $urandom_range(0, 15);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ln * rp + 2) : -1;
            run_req(8'($urandom), ln, rp, ab, 1'b0);
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                @(negedge clk);
                check("gap_ready", bus.start_ready, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
